// File: rtl/ising_axil_cell_ctrl_if.sv
// Purpose: AXI4-Lite slave channel bundle between the host interconnect and the spin-cell controller.
// Latency: none; this is a wire bundle.
// Backpressure: plain valid/ready on every channel (AW, W, B, AR, R).
//
// Ports (signals): s_aw* write address, s_w* write data, s_b* write response,
// s_ar* read address, s_r* read data/response. The slave modport is the
// controller's view and the master modport is the host's view.
interface ising_axil_cell_ctrl_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        input  s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp,
        output s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        output s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp,
        input  s_arready, s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/ising_axil_cell_ctrl.sv
// Purpose: AXI4-Lite slave that strobes writes into the spin-cell array, muxes cell rdata back, and owns ising_rstn.
// Latency: write strobe in the cycle after the AW+W handshake, with B one cycle later; R valid one cycle after the AR handshake.
// Backpressure: AW/W are refused until B is accepted; AR is refused until R is accepted.
//
// Ports: clk, axi_rst (async, active high); axi = AXI4-Lite slave bundle;
// wready/wr_addr_match/wdata = broadcast cell write port; cell_rdata = all
// cell read words, cell i at [32*i+31:32*i]; ising_rstn = array load(0)/run(1).
module ising_axil_cell_ctrl #(
    parameter int unsigned NUM_CELLS = 8,
    parameter logic [31:0] CELL_BASE = 32'h0000_0100,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      axi_rst,
    ising_axil_cell_ctrl_if.slave     axi,
    output logic                      wready,
    output logic [NUM_CELLS-1:0]      wr_addr_match,
    output logic [31:0]               wdata,
    input  logic [32*NUM_CELLS-1:0]   cell_rdata,
    output logic                      ising_rstn
);

    localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [32:0] CELL_LO = {1'b0, CELL_BASE};
    localparam logic [32:0] CELL_HI = {1'b0, CELL_BASE} + 33'(4 * NUM_CELLS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic             cell_hit;
        logic             ctrl_hit;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Byte-lane bits are dropped before comparing, so any address within a
    // word decodes to that word. The 33-bit math keeps the end-of-range
    // compare correct even when the cell window touches the top of memory.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [32:0] a;
        logic [32:0] off;
        dec_t        d;
        a          = {1'b0, addr} & ~33'd3;
        off        = a - CELL_LO;
        d.cell_hit = (a >= CELL_LO) && (a < CELL_HI);
        d.ctrl_hit = !d.cell_hit && (a[31:0] == (CTRL_ADDR & ~32'd3));
        d.idx      = IDX_W'(off >> 2);
        return d;
    endfunction

    // ---------------------------------------------------------------- write
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;

    w_state_t    w_state, w_state_nxt;
    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic        aw_hs, w_hs;
    dec_t        w_dec;

    assign axi.s_awready = (w_state == W_IDLE) && !aw_held;
    assign axi.s_wready  = (w_state == W_IDLE) && !w_held;
    assign aw_hs         = axi.s_awvalid && axi.s_awready;
    assign w_hs          = axi.s_wvalid && axi.s_wready;
    assign w_dec         = decode(aw_addr_q);
    assign wdata         = w_data_q;

    always_comb begin
        w_state_nxt   = w_state;
        wready        = 1'b0;
        wr_addr_match = '0;
        axi.s_bvalid  = 1'b0;
        axi.s_bresp   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                // Either half may already be parked from an earlier cycle.
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    w_state_nxt = W_EXEC;
                end
            end
            W_EXEC: begin
                if (w_dec.cell_hit) begin
                    wready        = 1'b1;
                    wr_addr_match = NUM_CELLS'(1) << w_dec.idx;
                end
                w_state_nxt = W_RESP;
            end
            W_RESP: begin
                axi.s_bvalid = 1'b1;
                axi.s_bresp  = (w_dec.cell_hit || w_dec.ctrl_hit) ? RESP_OKAY : RESP_SLVERR;
                if (axi.s_bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            ising_rstn <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= axi.s_awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= axi.s_wdata;
            end
            if ((w_state == W_EXEC) && w_dec.ctrl_hit) begin
                ising_rstn <= w_data_q[0];
            end
            if ((w_state == W_RESP) && axi.s_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- read
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    r_state_t    r_state, r_state_nxt;
    logic        ar_hs;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    dec_t        r_dec;

    assign r_dec       = decode(axi.s_araddr);
    assign ar_hs       = axi.s_arvalid && axi.s_arready;
    assign axi.s_rdata = rdata_q;
    assign axi.s_rresp = rresp_q;

    always_comb begin
        r_state_nxt   = r_state;
        axi.s_arready = 1'b0;
        axi.s_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi.s_arready = 1'b1;
                if (axi.s_arvalid) begin
                    r_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                axi.s_rvalid = 1'b1;
                if (axi.s_rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // The cell word is captured at the AR handshake edge; a cell being
    // written in that same cycle only updates at that edge, so the read
    // returns the pre-write value.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                if (r_dec.cell_hit) begin
                    rdata_q <= cell_rdata[32*r_dec.idx +: 32];
                    rresp_q <= RESP_OKAY;
                end else if (r_dec.ctrl_hit) begin
                    rdata_q <= {31'b0, ising_rstn};
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ising_axil_cell_ctrl.sv
`timescale 1ns/1ps
module tb_ising_axil_cell_ctrl;

    localparam int          N         = 8;
    localparam logic [31:0] CELL_BASE = 32'h0000_0100;
    localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           axi_rst;
    logic           wready;
    logic [N-1:0]   wr_addr_match;
    logic [31:0]    wdata;
    logic [32*N-1:0] cell_rdata;
    logic           ising_rstn;

    ising_axil_cell_ctrl_if axi ();

    ising_axil_cell_ctrl #(
        .NUM_CELLS (N),
        .CELL_BASE (CELL_BASE),
        .CTRL_ADDR (CTRL_ADDR)
    ) dut (
        .clk           (clk),
        .axi_rst       (axi_rst),
        .axi           (axi),
        .wready        (wready),
        .wr_addr_match (wr_addr_match),
        .wdata         (wdata),
        .cell_rdata    (cell_rdata),
        .ising_rstn    (ising_rstn)
    );

    always #5 clk = ~clk;

    // Spin-cell register array: each cell captures wdata when strobed.
    logic [31:0] cells [N] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wready && wr_addr_match[i]) cells[i] <= wdata;
        end
    end
    always_comb begin
        for (int i = 0; i < N; i++) cell_rdata[32*i +: 32] = cells[i];
    end

    int strobe_cnt = 0;
    always @(posedge clk) if (wready) strobe_cnt <= strobe_cnt + 1;

    // Reference model: expected cell contents and control bit.
    logic [31:0] ref_mem [N];
    logic        ref_rstn;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = miss, 1 = cell (idx set), 2 = control register
    function automatic int ref_kind(input logic [31:0] a, output int idx);
        longint w;
        w   = longint'(a) - longint'(a % 4);
        idx = 0;
        if (w >= longint'(CELL_BASE) && w < longint'(CELL_BASE) + 4 * N) begin
            idx = int'((w - longint'(CELL_BASE)) / 4);
            return 1;
        end
        if (w == longint'(CTRL_ADDR)) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = CELL_BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(0, 3));
            3:       a = CTRL_ADDR + 32'($urandom_range(0, 3));
            4:       a = CELL_BASE + 32'(4 * N) + 32'(4 * $urandom_range(0, 3));
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly, input int b_dly);
        int kind, idx, s0, cyc;
        bit aw_done, w_done;
        logic [N-1:0] exp_match;
        kind    = ref_kind(addr, idx);
        s0      = strobe_cnt;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_dly) begin axi.s_awvalid = 1'b1; axi.s_awaddr = addr; end
            if (!w_done && cyc >= w_dly)   begin axi.s_wvalid  = 1'b1; axi.s_wdata  = data; end
            if (aw_done) check("awready_while_held", axi.s_awready, 0);
            if (w_done)  check("wready_while_held", axi.s_wready, 0);
            check("no_early_strobe", wready, 0);
            if (axi.s_awvalid && axi.s_awready) aw_done = 1;
            if (axi.s_wvalid && axi.s_wready)   w_done  = 1;
            tick();
            if (aw_done) axi.s_awvalid = 1'b0;
            if (w_done)  axi.s_wvalid  = 1'b0;
            cyc++;
            if (cyc > 50) begin
                check("write_handshake_timeout", 0, 1);
                axi.s_awvalid = 1'b0;
                axi.s_wvalid  = 1'b0;
                return;
            end
        end
        // Cycle after the handshake: strobe cycle.
        exp_match = (kind == 1) ? (N'(1) << idx) : '0;
        check("exec_wready", wready, kind == 1);
        check("exec_match", wr_addr_match, exp_match);
        if (kind == 1) check("exec_wdata", wdata, data);
        check("exec_no_bvalid", axi.s_bvalid, 0);
        if (kind == 1) ref_mem[idx] = data;
        else if (kind == 2) ref_rstn = data[0];
        tick();
        check("b_valid", axi.s_bvalid, 1);
        check("b_resp", axi.s_bresp, (kind == 0) ? 2'b10 : 2'b00);
        check("resp_wready_low", wready, 0);
        check("ising_rstn", ising_rstn, ref_rstn);
        check("awready_in_resp", axi.s_awready, 0);
        repeat (b_dly) tick();
        check("b_valid_held", axi.s_bvalid, 1);
        axi.s_bready = 1'b1;
        tick();
        axi.s_bready = 1'b0;
        check("b_done", axi.s_bvalid, 0);
        check("strobe_count", strobe_cnt - s0, (kind == 1) ? 1 : 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        int kind, idx;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        kind  = ref_kind(addr, idx);
        exp_d = (kind == 1) ? ref_mem[idx] : (kind == 2) ? {31'b0, ref_rstn} : 32'h0;
        exp_r = (kind == 0) ? 2'b10 : 2'b00;
        axi.s_arvalid = 1'b1;
        axi.s_araddr  = addr;
        check("arready_idle", axi.s_arready, 1);
        tick();
        axi.s_arvalid = 1'b0;
        check("r_valid", axi.s_rvalid, 1);
        check("r_data", axi.s_rdata, exp_d);
        check("r_resp", axi.s_rresp, exp_r);
        repeat (r_dly) tick();
        check("r_data_stable", axi.s_rdata, exp_d);
        axi.s_rready = 1'b1;
        tick();
        axi.s_rready = 1'b0;
        check("r_done", axi.s_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [31:0] pre, a, d;
        for (int i = 0; i < N; i++) ref_mem[i] = 32'h0;
        ref_rstn      = 1'b0;
        axi.s_awvalid = 1'b0; axi.s_awaddr = '0;
        axi.s_wvalid  = 1'b0; axi.s_wdata  = '0;
        axi.s_bready  = 1'b0;
        axi.s_arvalid = 1'b0; axi.s_araddr = '0;
        axi.s_rready  = 1'b0;
        axi_rst       = 1'b1;
        #2;
        check("rst_bvalid", axi.s_bvalid, 0);
        check("rst_rvalid", axi.s_rvalid, 0);
        check("rst_bresp", axi.s_bresp, 0);
        check("rst_rresp", axi.s_rresp, 0);
        check("rst_rdata", axi.s_rdata, 0);
        check("rst_wready", wready, 0);
        check("rst_match", wr_addr_match, 0);
        check("rst_wdata", wdata, 0);
        check("rst_ising_rstn", ising_rstn, 0);
        repeat (3) tick();
        axi_rst = 1'b0;
        tick();
        check("idle_awready", axi.s_awready, 1);
        check("idle_wready", axi.s_wready, 1);
        check("idle_arready", axi.s_arready, 1);

        // Directed cases
        axi_write(CELL_BASE + 32'h8, 32'h1, 0, 0, 0);
        axi_write(CELL_BASE + 32'h1C, 32'h0, 0, 3, 0);
        axi_write(CTRL_ADDR, 32'h1, 0, 0, 1);
        axi_read(CTRL_ADDR, 0);
        axi_write(CTRL_ADDR, 32'h0, 2, 0, 0);
        axi_read(CTRL_ADDR, 1);
        axi_write(32'h0000_0200, 32'hDEAD_BEEF, 0, 0, 0);
        axi_read(CELL_BASE + 32'(4 * N), 0);
        axi_read(CELL_BASE + 32'h8, 0);

        // Read of cell 3 sampled during the strobe cycle of a write to it
        axi_write(CELL_BASE + 32'hC, 32'h0, 0, 0, 0);
        pre = ref_mem[3];
        axi.s_awvalid = 1'b1; axi.s_awaddr = CELL_BASE + 32'hC;
        axi.s_wvalid  = 1'b1; axi.s_wdata  = 32'h1;
        tick();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        check("ovl_exec_wready", wready, 1);
        axi.s_arvalid = 1'b1; axi.s_araddr = CELL_BASE + 32'hC;
        tick();
        axi.s_arvalid = 1'b0;
        ref_mem[3] = 32'h1;
        check("ovl_rvalid", axi.s_rvalid, 1);
        check("ovl_read_old", axi.s_rdata, pre);
        check("ovl_bvalid", axi.s_bvalid, 1);
        axi.s_bready = 1'b1; axi.s_rready = 1'b1;
        tick();
        axi.s_bready = 1'b0; axi.s_rready = 1'b0;
        axi_read(CELL_BASE + 32'hC, 0);

        // Reset while the write response is pending
        axi_write(CTRL_ADDR, 32'h1, 0, 0, 0);
        axi.s_awvalid = 1'b1; axi.s_awaddr = CELL_BASE + 32'h14;
        axi.s_wvalid  = 1'b1; axi.s_wdata  = 32'hA5A5_0005;
        tick();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        ref_mem[5] = 32'hA5A5_0005;
        tick();
        check("pre_rst_bvalid", axi.s_bvalid, 1);
        axi_rst = 1'b1;
        #1;
        check("async_rst_bvalid", axi.s_bvalid, 0);
        check("async_rst_rstn", ising_rstn, 0);
        ref_rstn = 1'b0;
        tick();
        axi_rst = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_awready", axi.s_awready, 1);
            check("post_rst_bvalid", axi.s_bvalid, 0);
        end
        check("post_rst_no_strobe", strobe_cnt - s0, 0);
        axi_read(CELL_BASE + 32'h14, 0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 80; t++) begin
            a = rand_addr();
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end
        for (int i = 0; i < N; i++) axi_read(CELL_BASE + 32'(4 * i), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
